// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth multiply sequencer driving an external shared adder-subtractor.
// One Booth iteration per cycle; done pulses once when the 2*WIDTH-bit product is ready.
module booth_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_m,
  output logic [1:0]       as_op,
  input  logic [WIDTH-1:0] as_result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [WIDTH-1:0] m_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] prod_hi_q;
  logic [WIDTH-1:0] prod_lo_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       as_op_q;

  logic             ovf;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] q_d;

  // Sign recovery: when A +/- M overflows, the true sign is the inverse of r's MSB.
  always_comb begin
    ovf = 1'b0;
    case (as_op_q)
      2'b01:   ovf = (a_q[WIDTH-1] == m_q[WIDTH-1]) && (as_result[WIDTH-1] != a_q[WIDTH-1]);
      2'b10:   ovf = (a_q[WIDTH-1] != m_q[WIDTH-1]) && (as_result[WIDTH-1] != a_q[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
    a_d = {as_result[WIDTH-1] ^ ovf, as_result[WIDTH-1:1]};
    q_d = {as_result[0], q_q[WIDTH-1:1]};
  end

  // Sequencer: operand latch, Booth iterations, completion pulse and product capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      as_op_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= start;
          if (start) begin
            a_q     <= '0;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            m_q     <= multiplicand;
            cnt_q   <= '0;
            as_op_q <= {multiplier[0], 1'b0};
            state_q <= CALC;
          end else begin
            as_op_q <= 2'b00;
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q + CW'(1);
          // Next op pair is {new Q[0], new q_1} = {Q[1], Q[0]} of the current value.
          if (cnt_q == CW'(WIDTH - 1)) begin
            as_op_q <= 2'b00;
            state_q <= DONE;
          end else begin
            as_op_q <= {q_q[1], q_q[0]};
            state_q <= CALC;
          end
        end
        DONE: begin
          done_q    <= 1'b1;
          prod_hi_q <= a_q;
          prod_lo_q <= q_q;
          as_op_q   <= 2'b00;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          as_op_q <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign product_hi = prod_hi_q;
  assign product_lo = prod_lo_q;
  assign as_a       = a_q;
  assign as_m       = m_q;
  assign as_op      = as_op_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: models the adder-subtractor and checks
// products against plain signed multiplication, plus cycle timing and reset abort.
module tb_booth_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [31:0] as_a;
  logic [31:0] as_m;
  logic [1:0]  as_op;
  logic [31:0] as_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_prod = 64'd0;

  booth_mul_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done),
    .product_hi(product_hi), .product_lo(product_lo),
    .as_a(as_a), .as_m(as_m), .as_op(as_op), .as_result(as_result)
  );

  // External adder-subtractor: 01 add, 10 subtract, else pass A
  assign as_result = (as_op == 2'b01) ? as_a + as_m :
                     (as_op == 2'b10) ? as_a - as_m : as_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint sm, sq;
    sm = longint'($signed(m));
    sq = longint'($signed(q));
    return 64'(sm * sq);
  endfunction

  // Launch one multiply; sample 1ns after each edge; k=0 is just after the start edge.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int inj1, input int inj2,
                        output int done_k, output int done_cnt, output int busy_cnt,
                        output logic [1:0] op0, output logic [63:0] prod,
                        output logic [63:0] mid_prod, output bit timeout);
    done_k = -1; done_cnt = 0; busy_cnt = 0; timeout = 1'b1;
    prod = 64'd0; mid_prod = 64'd0; op0 = 2'b00;
    @(negedge clk);
    multiplicand = m; multiplier = q; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k == 0) op0 = as_op;
      if (k == 16) mid_prod = {product_hi, product_lo};
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
        prod = {product_hi, product_lo};
      end
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      if (k == inj1 || k == inj2) begin
        multiplicand = $urandom; multiplier = $urandom; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; multiplicand = 32'd0; multiplier = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, as_op, as_a, as_m, product_hi, product_lo} !== 132'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b op=%b a=%h m=%h hi=%h lo=%h (want all zero)",
               busy, done, as_op, as_a, as_m, product_hi, product_lo);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b (want 0 0)", busy, done);
    end
  endtask

  task automatic test_basic;
    int dk, dc, bc; logic [1:0] op0; logic [63:0] p, mp; bit to;
    run_op(32'd5, 32'd2, -1, -1, dk, dc, bc, op0, p, mp, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: busy never fell"); end
    n_checks++;
    if (dk !== 33) begin n_fail++; $display("FAIL basic_done_latency: got %0d want 33", dk); end
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    n_checks++;
    if (bc !== 34) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 34", bc); end
    n_checks++;
    if (p !== 64'h00000000_0000000A) begin n_fail++; $display("FAIL basic_product: got %h want %h", p, 64'hA); end
    n_checks++;
    if (mp !== last_prod) begin n_fail++; $display("FAIL basic_product_hold: got %h want %h", mp, last_prod); end
    last_prod = p;
  endtask

  task automatic test_negative;
    int dk, dc, bc; logic [1:0] op0; logic [63:0] p, mp; bit to;
    run_op(32'hFFFFFFFD, 32'd7, -1, -1, dk, dc, bc, op0, p, mp, to);
    n_checks++;
    if (p !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL neg_product: got %h want %h", p, 64'hFFFFFFFF_FFFFFFEB); end
    n_checks++;
    if (op0 !== 2'b10) begin n_fail++; $display("FAIL neg_first_op: got %b want 10", op0); end
    n_checks++;
    if (mp !== last_prod) begin n_fail++; $display("FAIL neg_product_hold: got %h want %h", mp, last_prod); end
    last_prod = p;
  endtask

  task automatic test_corners;
    logic [31:0] ms [5] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] qs [5] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    int dk, dc, bc; logic [1:0] op0; logic [63:0] p, mp, exp; bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(ms[i], qs[i], -1, -1, dk, dc, bc, op0, p, mp, to);
      exp = ref_mul(ms[i], qs[i]);
      n_checks++;
      if (p !== exp || dc !== 1) begin
        n_fail++;
        $display("FAIL corner_%0d: %h*%h got %h (dones %0d) want %h (dones 1)", i, ms[i], qs[i], p, dc, exp);
      end
      last_prod = p;
    end
    n_checks++;
    if (ref_mul(32'h80000000, 32'h80000000) !== 64'h40000000_00000000) begin
      n_fail++; $display("FAIL ref_model_sanity: got %h want 4000000000000000", ref_mul(32'h80000000, 32'h80000000));
    end
  endtask

  task automatic test_random;
    int dk, dc, bc; logic [1:0] op0; logic [63:0] p, mp, exp; bit to;
    logic [31:0] m, q;
    for (int i = 0; i < 12; i++) begin
      m = $urandom; q = $urandom;
      if (i % 4 == 1) m = m & 32'h0000FFFF;
      if (i % 4 == 2) q = q | 32'h80000000;
      run_op(m, q, -1, -1, dk, dc, bc, op0, p, mp, to);
      exp = ref_mul(m, q);
      n_checks++;
      if (p !== exp || dk !== 33 || bc !== 34) begin
        n_fail++;
        $display("FAIL random_%0d: %h*%h got %h done@%0d busy%0d want %h done@33 busy34", i, m, q, p, dk, bc, exp);
      end
      n_checks++;
      if (mp !== last_prod) begin n_fail++; $display("FAIL random_hold_%0d: got %h want %h", i, mp, last_prod); end
      last_prod = p;
    end
  endtask

  task automatic test_ignored_start;
    int dk, dc, bc; logic [1:0] op0; logic [63:0] p, mp; bit to;
    run_op(32'd6, 32'd7, 5, 32, dk, dc, bc, op0, p, mp, to);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dc !== 1 || p !== 64'd42) begin n_fail++; $display("FAIL ignored_start: dones %0d product %h want 1 and 2a", dc, p); end
    n_checks++;
    if (busy !== 1'b0 || bc !== 34) begin n_fail++; $display("FAIL ignored_start_busy: busy=%b cycles=%0d want 0 and 34", busy, bc); end
    last_prod = p;
  endtask

  task automatic test_back_to_back;
    logic [31:0] m1, q1, m2, q2;
    int dones = 0; int k1 = -1; int k2 = -1; bit gap = 1'b0;
    logic [63:0] p1 = 64'd0; logic [63:0] p2 = 64'd0;
    m1 = $urandom; q1 = $urandom; m2 = $urandom; q2 = $urandom;
    @(negedge clk);
    multiplicand = m1; multiplier = q1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy && k < 68) gap = 1'b1;
      if (done) begin
        dones++;
        if (dones == 1) begin k1 = k; p1 = {product_hi, product_lo}; end
        else begin k2 = k; p2 = {product_hi, product_lo}; end
      end
      if (k >= 68 && !busy) break;
      if (k == 33) begin multiplicand = m2; multiplier = q2; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (k1 !== 33 || p1 !== ref_mul(m1, q1)) begin n_fail++; $display("FAIL b2b_first: done@%0d %h want 33 %h", k1, p1, ref_mul(m1, q1)); end
    n_checks++;
    if (k2 !== 67 || p2 !== ref_mul(m2, q2)) begin n_fail++; $display("FAIL b2b_second: done@%0d %h want 67 %h", k2, p2, ref_mul(m2, q2)); end
    n_checks++;
    if (gap !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap: busy dropped between operations"); end
    last_prod = p2;
  endtask

  task automatic test_reset_abort;
    int dc = 0; int dk, dc2, bc; logic [1:0] op0; logic [63:0] p, mp; bit to;
    @(negedge clk);
    multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, as_op, as_a, as_m, product_hi, product_lo} !== 132'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b op=%b a=%h m=%h hi=%h lo=%h (want all zero)",
               busy, done, as_op, as_a, as_m, product_hi, product_lo);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    n_checks++;
    if (dc !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: dones %0d busy %b want 0 0", dc, busy); end
    run_op(32'd9, 32'd9, -1, -1, dk, dc2, bc, op0, p, mp, to);
    n_checks++;
    if (p !== 64'd81) begin n_fail++; $display("FAIL after_abort_product: got %h want 51", p); end
    n_checks++;
    if (mp !== 64'd0) begin n_fail++; $display("FAIL after_abort_hold: got %h want 0", mp); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_corners;
    test_random;
    test_ignored_start;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
